// File: rtl/mem_arbiter_burst.sv
`timescale 1ns/1ps
// mem_arbiter_burst
//
// Purpose:
//   Shares one burst memory port between the L1 icache and dcache.
//   A granted cacheline transfer is split into BEATS beats of BEAT_WIDTH
//   bits. Read beats are reassembled into a line buffer and handed back to
//   the requesting cache together with a single-cycle resp pulse.
//   The dcache always has priority over the icache, and a dcache writeback
//   has priority over a dcache read.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   i_read     icache line read request, held until i_resp
//   i_addr     icache line address
//   i_rdata    assembled line for the icache (valid while i_resp is high)
//   i_resp     one-cycle completion pulse to the icache
//   d_read     dcache line read request, held until d_resp
//   d_write    dcache writeback request, held until d_resp
//   d_addr     dcache line address
//   d_wdata    dcache writeback line
//   d_rdata    assembled line for the dcache (valid while d_resp is high)
//   d_resp     one-cycle completion pulse to the dcache
//   mem_read   burst read request to memory
//   mem_write  burst write request to memory
//   mem_addr   line-aligned burst address
//   mem_wdata  current write beat
//   mem_rdata  current read beat from memory
//   mem_resp   memory accepted / delivered one beat this cycle
module mem_arbiter_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    IRD,
    DRD,
    DWR,
    RESP_I,
    RESP_D
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [BEAT_BITS-1:0]  beat;
  logic [LINE_WIDTH-1:0] line;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  in_burst;
  logic                  last_beat;

  assign in_burst  = (state == IRD) || (state == DRD) || (state == DWR);
  assign last_beat = in_burst && mem_resp && (beat == LAST_BEAT);

  // State register. Because every output is decoded from the state and the
  // reset-cleared datapath, pulling rst low forces all outputs to zero
  // immediately, even in the middle of a burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, so anything the
  // caches do to their request, address or data lines after the grant has
  // no effect until the burst and its resp cycle are over. The resp states
  // always last one cycle, which guarantees at least one IDLE cycle between
  // bursts in which fresh requests are sampled.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_write) begin
          state_next = DWR;
        end else if (d_read) begin
          state_next = DRD;
        end else if (i_read) begin
          state_next = IRD;
        end
      end
      IRD: begin
        if (last_beat) begin
          state_next = RESP_I;
        end
      end
      DRD, DWR: begin
        if (last_beat) begin
          state_next = RESP_D;
        end
      end
      RESP_I, RESP_D: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: the address and (for writebacks) the line are captured at the
  // grant. During a burst the beat counter only moves on mem_resp, so wait
  // states from memory simply hold the current beat. Read beats are dropped
  // into the line buffer least-significant beat first; a writeback never
  // touches the buffer, which is why d_rdata echoes the written line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= '0;
      line <= '0;
      addr <= '0;
    end else begin
      if (state == IDLE) begin
        beat <= '0;
        if (d_write) begin
          addr <= d_addr;
          line <= d_wdata;
        end else if (d_read) begin
          addr <= d_addr;
        end else if (i_read) begin
          addr <= i_addr;
        end
      end else if (in_burst && mem_resp) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        if (state != DWR) begin
          line[beat*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
        end
      end
    end
  end

  assign mem_read  = (state == IRD) || (state == DRD);
  assign mem_write = (state == DWR);
  assign mem_addr  = in_burst ? {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
  assign mem_wdata = (state == DWR) ? line[beat*BEAT_WIDTH +: BEAT_WIDTH] : '0;
  assign i_resp    = (state == RESP_I);
  assign d_resp    = (state == RESP_D);
  assign i_rdata   = line;
  assign d_rdata   = line;

endmodule
